// File: rtl/cache_burst_axi.sv
`default_nettype none
// ============================================================================
// Module   : cache_burst_axi
// Brief    : Cache-line fill and writeback engine over AXI4 bursts, with an
//            early-restart word stream and optional critical-word-first reads.
// Revision : 1.0  initial release
// ============================================================================
module cache_burst_axi #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] AXI_ID     = 4'h1,
  parameter bit         WRAP_EN    = 1'b0
) (
  input  logic                          clk,
  input  logic                          resetn,
  // line read request / return
  input  logic                          rd_req,
  input  logic [31:0]                   rd_addr,
  output logic                          rd_rdy,
  output logic                          rd_word_valid,
  output logic [$clog2(LINE_WORDS)-1:0] rd_word_idx,
  output logic [31:0]                   rd_word,
  output logic                          ret_valid,
  output logic [32*LINE_WORDS-1:0]      ret_data,
  output logic                          ret_err,
  // line writeback request / completion
  input  logic                          wr_req,
  input  logic [31:0]                   wr_addr,
  input  logic [32*LINE_WORDS-1:0]      wr_data,
  output logic                          wr_rdy,
  output logic                          wr_bvalid,
  output logic                          wr_err,
  // AXI AR
  output logic [3:0]                    arid,
  output logic [31:0]                   araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arvalid,
  input  logic                          arready,
  // AXI R
  input  logic [3:0]                    rid,
  input  logic [31:0]                   rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready,
  // AXI AW
  output logic [3:0]                    awid,
  output logic [31:0]                   awaddr,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic                          awvalid,
  input  logic                          awready,
  // AXI W
  output logic [31:0]                   wdata,
  output logic [3:0]                    wstrb,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  // AXI B
  input  logic [3:0]                    bid,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready
);

  localparam int                   c_IDX_W = $clog2(LINE_WORDS);
  localparam int                   c_OFF_W = c_IDX_W + 2;
  localparam logic [c_IDX_W-1:0]   c_LAST  = c_IDX_W'(LINE_WORDS - 1);
  localparam logic [7:0]           c_LEN   = 8'(LINE_WORDS - 1);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_DATA = 2'd1;
  localparam logic [1:0] R_DONE = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [1:0]              r_rd_state;
  logic [1:0]              w_rd_next;
  logic [1:0]              r_wr_state;
  logic [1:0]              w_wr_next;

  logic [c_IDX_W-1:0]      r_rd_beat;
  logic [c_IDX_W-1:0]      r_start_word;
  logic [c_IDX_W-1:0]      w_start_word;
  logic [c_IDX_W-1:0]      w_slot;
  logic [32*LINE_WORDS-1:0] r_ret_data;
  logic                    r_ret_err;
  logic                    w_beat_err;

  logic [c_IDX_W-1:0]      r_wr_beat;
  logic [32*LINE_WORDS-1:0] r_wr_data;
  logic [31:c_OFF_W]       r_wr_line;
  logic                    r_wr_err;
  logic                    w_hazard;
  logic                    w_unused;

  // ------------------------------------------------------------------------
  // Address channels
  // ------------------------------------------------------------------------
  generate
    if (WRAP_EN) begin : g_wrap
      assign araddr       = {rd_addr[31:2], 2'b00};
      assign arburst      = 2'b10;
      assign w_start_word = rd_addr[c_OFF_W-1:2];
    end else begin : g_incr
      assign araddr       = {rd_addr[31:c_OFF_W], {c_OFF_W{1'b0}}};
      assign arburst      = 2'b01;
      assign w_start_word = '0;
    end
  endgenerate

  assign arid    = AXI_ID;
  assign arlen   = c_LEN;
  assign arsize  = 3'b010;
  assign awid    = AXI_ID;
  assign awaddr  = {wr_addr[31:c_OFF_W], {c_OFF_W{1'b0}}};
  assign awlen   = c_LEN;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wstrb   = 4'hF;

  // A read may not overtake a writeback of the same line, including one being
  // requested in this very cycle.
  always_comb begin
    w_hazard = 1'b0;
    if (r_wr_state != W_IDLE)
      w_hazard = (rd_addr[31:c_OFF_W] == r_wr_line);
    else if (wr_req)
      w_hazard = (rd_addr[31:c_OFF_W] == wr_addr[31:c_OFF_W]);
  end

  // ------------------------------------------------------------------------
  // Read FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rd_state <= R_IDLE;
    else         r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (rd_rdy) w_rd_next = R_DATA;
      R_DATA:  if (rd_word_valid && (r_rd_beat == c_LAST)) w_rd_next = R_DONE;
      R_DONE:  w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    if (resetn) begin
      arvalid   = (r_rd_state == R_IDLE) && rd_req && !w_hazard;
      rready    = (r_rd_state == R_DATA);
      ret_valid = (r_rd_state == R_DONE);
    end
    rd_rdy        = arvalid && arready;
    rd_word_valid = rready && rvalid;
  end

  assign w_slot      = r_start_word + r_rd_beat;
  assign rd_word_idx = w_slot;
  assign rd_word     = rdata;
  assign ret_data    = r_ret_data;
  assign ret_err     = r_ret_err;
  assign w_beat_err  = rresp[1] || (rlast != (r_rd_beat == c_LAST));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_beat    <= '0;
      r_start_word <= '0;
      r_ret_data   <= '0;
      r_ret_err    <= 1'b0;
    end else if (rd_rdy) begin
      r_start_word <= w_start_word;
      r_rd_beat    <= '0;
      r_ret_err    <= 1'b0;
    end else if (rd_word_valid) begin
      r_ret_data[w_slot*32 +: 32] <= rdata;
      r_rd_beat                   <= r_rd_beat + 1'b1;
      if (w_beat_err) r_ret_err <= 1'b1;
    end else if (r_rd_state != R_DATA) begin
      r_rd_beat <= '0;
    end
  end

  // ------------------------------------------------------------------------
  // Write FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_wr_state <= W_IDLE;
    else         r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (wr_rdy) w_wr_next = W_DATA;
      W_DATA:  if (wvalid && wready && (r_wr_beat == c_LAST)) w_wr_next = W_RESP;
      W_RESP:  if (wr_bvalid) w_wr_next = W_IDLE;
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    if (resetn) begin
      awvalid = (r_wr_state == W_IDLE) && wr_req;
      wvalid  = (r_wr_state == W_DATA);
      bready  = (r_wr_state == W_RESP);
    end
    wr_rdy    = awvalid && awready;
    wlast     = wvalid && (r_wr_beat == c_LAST);
    wr_bvalid = bready && bvalid;
    wdata     = r_wr_data[r_wr_beat*32 +: 32];
    wr_err    = wr_bvalid ? bresp[1] : r_wr_err;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_beat <= '0;
      r_wr_data <= '0;
      r_wr_line <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      if (wr_rdy) begin
        r_wr_data <= wr_data;
        r_wr_line <= wr_addr[31:c_OFF_W];
        r_wr_beat <= '0;
      end else if (wvalid && wready) begin
        r_wr_beat <= r_wr_beat + 1'b1;
      end else if (r_wr_state != W_DATA) begin
        r_wr_beat <= '0;
      end
      if (wr_bvalid) r_wr_err <= bresp[1];
    end
  end

  // IDs are never checked; sub-line address bits are intentionally dropped.
  assign w_unused = ^{rid, bid, rresp[0], bresp[0],
                      rd_addr[c_OFF_W-1:0], wr_addr[c_OFF_W-1:0]};

endmodule
`default_nettype wire
